vga_rx: RTL and testbench



---
 rtl/vga_rx_if.sv | 37 +++
 rtl/vga_rx.sv | 192 +++++++++++++++++++
 tb/tb_vga_rx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rx_if.sv
// VGA receiver bus: sampled video inputs, probe request and decoded outputs.
interface vga_rx_if;
    // video source side
    logic       pix_en;
    logic       VGA_hs;
    logic       VGA_vs;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic [9:0] probe_x;
    logic [8:0] probe_y;
    // receiver results
    logic       locked;
    logic       pix_valid;
    logic [9:0] x;
    logic [8:0] y;
    logic [11:0] rgb;
    logic       frame_start;
    logic       sync_err;
    logic [7:0] frame_cnt;
    logic [11:0] probe_rgb;
    logic       probe_done;

    // master drives video and probe request, consumes results
    modport master (
        output pix_en, VGA_hs, VGA_vs, VGA_R, VGA_G, VGA_B, probe_x, probe_y,
        input  locked, pix_valid, x, y, rgb, frame_start, sync_err,
               frame_cnt, probe_rgb, probe_done
    );

    // slave is the receiver itself
    modport slave (
        input  pix_en, VGA_hs, VGA_vs, VGA_R, VGA_G, VGA_B, probe_x, probe_y,
        output locked, pix_valid, x, y, rgb, frame_start, sync_err,
               frame_cnt, probe_rgb, probe_done
    );
endinterface

// File: rtl/vga_rx.sv
// VGA timing receiver: tracks hsync/vsync, locks onto a clean frame
// geometry, emits active pixels with coordinates and captures one probed pixel.
module vga_rx #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic     clk,
    input  logic     rstn,
    vga_rx_if.slave  io_vga
);
    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    // Counter value seen at a sync edge when the line/frame had the nominal length
    localparam logic [9:0] H_END = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_END = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ST  = 10'(H_START);
    localparam logic [9:0] H_EN  = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_ST  = 10'(V_START);
    localparam logic [9:0] V_EN  = 10'(V_START + V_ACTIVE);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic [1:0]  r_state;
    logic        r_line_bad;
    logic        r_pix_valid;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [11:0] r_rgb;
    logic        r_frame_start;
    logic        r_sync_err;
    logic [7:0]  r_frame_cnt;
    logic [9:0]  r_probe_x;
    logic [8:0]  r_probe_y;
    logic [11:0] r_probe_rgb;
    logic        r_probe_done;

    logic        w_hs_fall;
    logic        w_vs_fall;
    logic        w_line_fail;
    logic        w_frame_ok;
    logic        w_active;
    logic [9:0]  w_x;
    logic [8:0]  w_y;
    logic [11:0] w_rgb;
    logic        w_probe_hit;
    logic [1:0]  w_state_nxt;
    logic        w_line_bad_nxt;
    logic        w_sync_err;
    logic        w_frame_start;

    assign w_hs_fall   = r_hs_prev & ~io_vga.VGA_hs;
    assign w_vs_fall   = r_vs_prev & ~io_vga.VGA_vs;
    assign w_line_fail = w_hs_fall & (r_hcnt != H_END);
    assign w_frame_ok  = (r_vcnt == V_END);
    assign w_active    = (r_state == S_LOCKED) &&
                         (r_hcnt >= H_ST) && (r_hcnt < H_EN) &&
                         (r_vcnt >= V_ST) && (r_vcnt < V_EN);
    assign w_x         = r_hcnt - H_ST;
    assign w_y         = 9'(r_vcnt - V_ST);
    assign w_rgb       = {io_vga.VGA_R, io_vga.VGA_G, io_vga.VGA_B};
    assign w_probe_hit = (w_x == r_probe_x) && (w_y == r_probe_y);

    // Lock FSM next state; sync failure in LOCKED suppresses frame_start
    always_comb begin
        w_state_nxt    = r_state;
        w_line_bad_nxt = r_line_bad;
        w_sync_err     = 1'b0;
        w_frame_start  = 1'b0;
        case (r_state)
            S_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt    = S_ACQUIRE;
                    w_line_bad_nxt = 1'b0;
                end
            end
            S_ACQUIRE: begin
                if (w_vs_fall) begin
                    w_line_bad_nxt = 1'b0;
                    if (w_frame_ok && !r_line_bad && !w_line_fail) begin
                        w_state_nxt   = S_LOCKED;
                        w_frame_start = 1'b1;
                    end
                end else if (w_line_fail) begin
                    w_line_bad_nxt = 1'b1;
                end
            end
            S_LOCKED: begin
                if (w_line_fail || (w_vs_fall && !w_frame_ok)) begin
                    w_state_nxt = S_SEARCH;
                    w_sync_err  = 1'b1;
                end else if (w_vs_fall) begin
                    w_frame_start = 1'b1;
                end
            end
            default: w_state_nxt = S_SEARCH;
        endcase
    end

    // Sync edge history and line/frame position counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hs_prev <= 1'b1;
            r_vs_prev <= 1'b1;
            r_hcnt    <= 10'd0;
            r_vcnt    <= 10'd0;
        end else if (io_vga.pix_en) begin
            r_hs_prev <= io_vga.VGA_hs;
            r_vs_prev <= io_vga.VGA_vs;
            r_hcnt    <= w_hs_fall ? 10'd0 : sat_inc(r_hcnt);
            if (w_vs_fall) begin
                r_vcnt <= 10'd0;
            end else if (w_hs_fall) begin
                r_vcnt <= sat_inc(r_vcnt);
            end
        end
    end

    // Lock state, frame bookkeeping and single-cycle status pulses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_SEARCH;
            r_line_bad    <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_probe_x     <= 10'd0;
            r_probe_y     <= 9'd0;
        end else begin
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            if (io_vga.pix_en) begin
                r_state       <= w_state_nxt;
                r_line_bad    <= w_line_bad_nxt;
                r_sync_err    <= w_sync_err;
                r_frame_start <= w_frame_start;
                if (w_frame_start) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    r_probe_x   <= io_vga.probe_x;
                    r_probe_y   <= io_vga.probe_y;
                end
            end
        end
    end

    // Active pixel output and probe capture; coordinates hold between pixels
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pix_valid  <= 1'b0;
            r_x          <= 10'd0;
            r_y          <= 9'd0;
            r_rgb        <= 12'd0;
            r_probe_rgb  <= 12'd0;
            r_probe_done <= 1'b0;
        end else begin
            r_pix_valid  <= 1'b0;
            r_probe_done <= 1'b0;
            if (io_vga.pix_en && w_active) begin
                r_pix_valid <= 1'b1;
                r_x         <= w_x;
                r_y         <= w_y;
                r_rgb       <= w_rgb;
                if (w_probe_hit) begin
                    r_probe_rgb  <= w_rgb;
                    r_probe_done <= 1'b1;
                end
            end
        end
    end

    assign io_vga.locked      = (r_state == S_LOCKED);
    assign io_vga.pix_valid   = r_pix_valid;
    assign io_vga.x           = r_x;
    assign io_vga.y           = r_y;
    assign io_vga.rgb         = r_rgb;
    assign io_vga.frame_start = r_frame_start;
    assign io_vga.sync_err    = r_sync_err;
    assign io_vga.frame_cnt   = r_frame_cnt;
    assign io_vga.probe_rgb   = r_probe_rgb;
    assign io_vga.probe_done  = r_probe_done;
endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx with reduced frame geometry: directed frames, scoreboard
// queues for pixels, frame starts, sync errors and probe captures.
module tb_vga_rx;
    localparam int HT = 16;
    localparam int HS = 3;
    localparam int HA = 10;
    localparam int VT = 10;
    localparam int VS = 2;
    localparam int VA = 6;
    localparam int HS_W = 2;
    localparam int VS_W = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    vga_rx_if vif ();

    vga_rx #(
        .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .io_vga(vif.slave)
    );

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    bit gaps_on = 1'b1;

    logic [30:0] pix_q[$];
    logic [7:0]  fs_q[$];
    bit          se_q[$];
    logic [11:0] pr_q[$];

    logic [30:0] last_pix = '0;
    logic [7:0]  exp_cnt = '0;
    logic [9:0]  px_lat = '0;
    logic [8:0]  py_lat = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one pix_en sample, then optional idle clocks with junk on the inputs
    task automatic sample(input logic hs, input logic vs, input logic [11:0] c);
        vif.pix_en = 1'b1;
        vif.VGA_hs = hs;
        vif.VGA_vs = vs;
        {vif.VGA_R, vif.VGA_G, vif.VGA_B} = c;
        @(negedge clk);
        vif.pix_en = 1'b0;
        if (gaps_on) begin
            repeat ($urandom_range(0, 2)) begin
                vif.VGA_hs = 1'($urandom);
                vif.VGA_vs = 1'($urandom);
                {vif.VGA_R, vif.VGA_G, vif.VGA_B} = 12'($urandom);
                @(negedge clk);
            end
        end
    endtask

    // line L of a frame; hs falls at s=0, so the counter reads s-1 at sample s
    task automatic send_line(input int L, input int len, input bit lk);
        for (int s = 0; s < len; s++) begin
            logic [11:0] c;
            int px, py;
            c = 12'($urandom);
            px = s - 1 - HS;
            py = L - VS;
            if (lk && px >= 0 && px < HA && py >= 0 && py < VA) begin
                pix_q.push_back({10'(px), 9'(py), c});
                if (px == int'(px_lat) && py == int'(py_lat)) pr_q.push_back(c);
            end
            sample((s < HS_W) ? 1'b0 : 1'b1, (L < VS_W) ? 1'b0 : 1'b1, c);
        end
    endtask

    // event produced by the vs edge opening a frame: 0 none, 1 frame_start, 2 sync_err
    task automatic open_frame(input int evt);
        if (evt == 1) begin
            exp_cnt++;
            fs_q.push_back(exp_cnt);
            px_lat = vif.probe_x;
            py_lat = vif.probe_y;
        end else if (evt == 2) begin
            se_q.push_back(1'b1);
        end
    endtask

    task automatic send_frame(input bit lk_in, input int evt, input int short_ln);
        bit lk;
        lk = lk_in;
        open_frame(evt);
        for (int L = 0; L < VT; L++) begin
            if (lk && short_ln >= 0 && L == short_ln + 1) begin
                se_q.push_back(1'b1);
                lk = 1'b0;
            end
            send_line(L, (L == short_ln) ? HT - 1 : HT, lk);
        end
    endtask

    task automatic do_reset();
        vif.pix_en = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        last_pix = '0;
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_locked", 32'(vif.locked), 32'd0);
        chk("rst_pix_valid", 32'(vif.pix_valid), 32'd0);
        chk("rst_x", 32'(vif.x), 32'd0);
        chk("rst_y", 32'(vif.y), 32'd0);
        chk("rst_rgb", 32'(vif.rgb), 32'd0);
        chk("rst_frame_start", 32'(vif.frame_start), 32'd0);
        chk("rst_sync_err", 32'(vif.sync_err), 32'd0);
        chk("rst_frame_cnt", 32'(vif.frame_cnt), 32'd0);
        chk("rst_probe_rgb", 32'(vif.probe_rgb), 32'd0);
        chk("rst_probe_done", 32'(vif.probe_done), 32'd0);
        rstn = 1'b1;
        exp_cnt = '0;
        mon_en = 1'b1;
    endtask

    // scoreboard consumer: every output event must match the oldest expectation
    always @(negedge clk) begin : mon
        logic [30:0] e;
        if (mon_en) begin
            if (vif.pix_valid) begin
                if (pix_q.size() == 0) chk("pix_unexpected", 32'(vif.pix_valid), 32'd0);
                else begin
                    e = pix_q.pop_front();
                    chk("pixel", 32'({vif.x, vif.y, vif.rgb}), 32'(e));
                    last_pix = e;
                end
            end else begin
                chk("pixel_hold", 32'({vif.x, vif.y, vif.rgb}), 32'(last_pix));
            end
            if (vif.frame_start) begin
                if (fs_q.size() == 0) chk("fs_unexpected", 32'(vif.frame_start), 32'd0);
                else chk("frame_cnt", 32'(vif.frame_cnt), 32'(fs_q.pop_front()));
            end
            if (vif.sync_err) begin
                if (se_q.size() == 0) chk("serr_unexpected", 32'(vif.sync_err), 32'd0);
                else begin
                    void'(se_q.pop_front());
                    chk("serr_unlocked", 32'(vif.locked), 32'd0);
                    chk("serr_no_fs", 32'(vif.frame_start), 32'd0);
                end
            end
            if (vif.probe_done) begin
                if (pr_q.size() == 0) chk("probe_unexpected", 32'(vif.probe_done), 32'd0);
                else chk("probe_rgb", 32'(vif.probe_rgb), 32'(pr_q.pop_front()));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.pix_en = 1'b0;
        vif.VGA_hs = 1'b1;
        vif.VGA_vs = 1'b1;
        {vif.VGA_R, vif.VGA_G, vif.VGA_B} = 12'd0;
        vif.probe_x = 10'd0;
        vif.probe_y = 9'd0;
        repeat (2) @(negedge clk);
        do_reset();

        // acquire with a short first line: no lock after that frame
        send_frame(1'b0, 0, 0);
        send_frame(1'b0, 0, -1);
        chk("acq_bad_line_locked", 32'(vif.locked), 32'd0);
        // clean frame in ACQUIRE: lock at the next vs edge
        send_frame(1'b1, 1, -1);
        chk("lock_locked", 32'(vif.locked), 32'd1);
        chk("lock_frame_cnt", 32'(vif.frame_cnt), 32'd1);

        // in-range probe, then out-of-range probes
        vif.probe_x = 10'd5;
        vif.probe_y = 9'd3;
        send_frame(1'b1, 1, -1);
        vif.probe_x = 10'(HA);
        vif.probe_y = 9'd3;
        send_frame(1'b1, 1, -1);
        vif.probe_x = 10'd2;
        vif.probe_y = 9'(VA);
        send_frame(1'b1, 1, -1);
        vif.probe_x = 10'(HA - 1);
        vif.probe_y = 9'(VA - 1);

        // short line while locked: sync error, relock needs two frames
        send_frame(1'b1, 1, 1);
        chk("short_line_locked", 32'(vif.locked), 32'd0);
        send_frame(1'b0, 0, -1);
        send_frame(1'b1, 1, -1);
        chk("relock_locked", 32'(vif.locked), 32'd1);

        // short last line: sync error coincides with the vs edge
        send_frame(1'b1, 1, VT - 1);
        send_frame(1'b0, 2, -1);
        chk("coinc_locked", 32'(vif.locked), 32'd0);
        chk("coinc_frame_cnt", 32'(vif.frame_cnt), 32'(exp_cnt));
        send_frame(1'b0, 0, -1);
        send_frame(1'b1, 1, -1);

        // run locked frames until the frame counter wraps to zero
        gaps_on = 1'b0;
        do send_frame(1'b1, 1, -1); while (exp_cnt != 8'd0);
        gaps_on = 1'b1;
        chk("wrap_frame_cnt", 32'(vif.frame_cnt), 32'd0);
        chk("wrap_locked", 32'(vif.locked), 32'd1);

        // reset in the middle of an active line
        open_frame(1);
        for (int L = 0; L < 4; L++) send_line(L, HT, 1'b1);
        send_line(4, 8, 1'b1);
        do_reset();

        // tail of the interrupted frame, then a fresh acquire and lock
        for (int L = 5; L < VT; L++) send_line(L, HT, 1'b0);
        chk("post_rst_locked", 32'(vif.locked), 32'd0);
        send_frame(1'b0, 0, -1);
        send_frame(1'b1, 1, -1);
        chk("post_rst_relock", 32'(vif.locked), 32'd1);
        chk("post_rst_frame_cnt", 32'(vif.frame_cnt), 32'd1);

        repeat (4) @(negedge clk);
        chk("pix_q_empty", 32'(pix_q.size()), 32'd0);
        chk("fs_q_empty", 32'(fs_q.size()), 32'd0);
        chk("se_q_empty", 32'(se_q.size()), 32'd0);
        chk("pr_q_empty", 32'(pr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
